// File: rtl/wu_banked_memory.sv
// wu_banked_memory: banked WU instruction store, two-stage read pipe and output FIFO to wud.
// Optional `WUM_INST_LIMIT_EN adds mcntl__wum__inst_limit, which holds the FIFO head at the limit.
`ifndef COMMON_STD_INTF_CNTL_SOM
`define COMMON_STD_INTF_CNTL_SOM 2'b01
`endif
`ifndef COMMON_STD_INTF_CNTL_MOM
`define COMMON_STD_INTF_CNTL_MOM 2'b00
`endif
`ifndef COMMON_STD_INTF_CNTL_EOM
`define COMMON_STD_INTF_CNTL_EOM 2'b10
`endif
`ifndef COMMON_STD_INTF_CNTL_SOM_EOM
`define COMMON_STD_INTF_CNTL_SOM_EOM 2'b11
`endif

module wu_banked_memory #(
  parameter int NUM_BANKS      = 2,
  parameter int DEPTH          = 1024,
  parameter int OPT_PER_INST   = 3,
  parameter int OPT_TYPE_W     = 8,
  parameter int OPT_VALUE_W    = 16,
  parameter int OP_W           = 2,
  parameter int CNTL_W         = 2,
  parameter int OUT_FIFO_DEPTH = 4,
  parameter int CNT_W          = 16,
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int W = 2*CNTL_W + OP_W
                   + OPT_PER_INST*(OPT_TYPE_W+OPT_VALUE_W)
) (
  input  logic                              clk,
  input  logic                              reset_poweron,
  input  logic [BANK_W-1:0]                 mcntl__wum__bank_sel,
`ifdef WUM_INST_LIMIT_EN
  input  logic [CNT_W-1:0]                  mcntl__wum__inst_limit,
`endif
  input  logic                              cfg__wum__write,
  input  logic [BANK_W-1:0]                 cfg__wum__bank,
  input  logic [ADDR_W-1:0]                 cfg__wum__addr,
  input  logic [W-1:0]                      cfg__wum__data,
  input  logic                              wuf__wum__read,
  input  logic [ADDR_W-1:0]                 wuf__wum__addr,
  output logic                              wum__wuf__stall,
  output logic                              wum__wud__valid,
  input  logic                              wud__wum__ready,
  output logic [CNTL_W-1:0]                 wum__wud__icntl,
  output logic [CNTL_W-1:0]                 wum__wud__dcntl,
  output logic [OP_W-1:0]                   wum__wud__op,
  output logic [OPT_PER_INST*OPT_TYPE_W-1:0]  wum__wud__option_type,
  output logic [OPT_PER_INST*OPT_VALUE_W-1:0] wum__wud__option_value,
  output logic [BANK_W-1:0]                 wum__mcntl__active_bank,
  output logic                              wum__mcntl__busy,
  output logic [CNT_W-1:0]                  wum__mcntl__inst_count,
  output logic                              wum__mcntl__err_wr
);

  localparam int PTR_W  = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(OUT_FIFO_DEPTH + 1);
  localparam int OCC_W  = $clog2(OUT_FIFO_DEPTH + 3);
  localparam int HDR_W  = 2*CNTL_W + OP_W;
  localparam int PAIR_W = OPT_TYPE_W + OPT_VALUE_W;

  logic [W-1:0]        mem_q [NUM_BANKS][DEPTH];
  logic [W-1:0]        fifo_q [OUT_FIFO_DEPTH];
  logic [BANK_W-1:0]   bank_q;
  logic                stall_q, stall_d;
  logic                s1_vld_q, s2_vld_q;
  logic [ADDR_W-1:0]   s1_addr_q;
  logic [W-1:0]        s2_data_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]    icnt_q, icnt_d;
  logic                err_q;

  logic                issue, push, pop, busy;
  logic                pending, commit, hold, wr_ok;
  logic [W-1:0]        head;
  logic [OCC_W-1:0]    occ_d;

  assign issue   = wuf__wum__read & ~stall_q;
  assign push    = s2_vld_q;
  assign busy    = s1_vld_q | s2_vld_q | (cnt_q != '0);
  assign pending = mcntl__wum__bank_sel != bank_q;
  assign commit  = pending & ~busy & ~issue;

`ifdef WUM_INST_LIMIT_EN
  assign hold = (mcntl__wum__inst_limit != '0) &
                (icnt_q == mcntl__wum__inst_limit);
`else
  assign hold = 1'b0;
`endif

  assign pop   = (cnt_q != '0) & ~hold & wud__wum__ready;
  // A load racing a commit into the same bank is treated as an active-bank load.
  assign wr_ok = cfg__wum__write & (cfg__wum__bank != bank_q) &
                 ~(commit & (cfg__wum__bank == mcntl__wum__bank_sel));

  always_comb begin
    cnt_d   = cnt_q + FCNT_W'(push) - FCNT_W'(pop);
    occ_d   = OCC_W'(cnt_d) + OCC_W'(issue) + OCC_W'(s1_vld_q);
    stall_d = (occ_d >= OCC_W'(OUT_FIFO_DEPTH)) | (pending & ~commit) | hold;
    icnt_d  = icnt_q;
    if (commit) begin
      icnt_d = '0;
    end else if (pop && icnt_q != '1 &&
                 head[CNTL_W-1:0] == CNTL_W'(`COMMON_STD_INTF_CNTL_EOM)) begin
      icnt_d = icnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      bank_q    <= '0;
      stall_q   <= 1'b1;
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      icnt_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      stall_q  <= stall_d;
      s1_vld_q <= issue;
      s2_vld_q <= s1_vld_q;
      if (issue) s1_addr_q <= wuf__wum__addr;
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_W'(OUT_FIFO_DEPTH-1)) ? '0
                    : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(OUT_FIFO_DEPTH-1)) ? '0
                    : rd_ptr_q + PTR_W'(1);
      end
      cnt_q  <= cnt_d;
      icnt_q <= icnt_d;
      if (commit) bank_q <= mcntl__wum__bank_sel;
      if (cfg__wum__write && !wr_ok) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[cfg__wum__bank][cfg__wum__addr] <= cfg__wum__data;
    if (s1_vld_q) s2_data_q <= mem_q[bank_q][s1_addr_q];
    if (push) fifo_q[wr_ptr_q] <= s2_data_q;
  end

  assign head = (cnt_q != '0) ? fifo_q[rd_ptr_q] : '0;

  assign wum__wuf__stall         = stall_q;
  assign wum__wud__valid         = (cnt_q != '0) & ~hold;
  assign wum__wud__icntl         = head[CNTL_W-1:0];
  assign wum__wud__dcntl         = head[CNTL_W +: CNTL_W];
  assign wum__wud__op            = head[2*CNTL_W +: OP_W];
  assign wum__mcntl__active_bank = bank_q;
  assign wum__mcntl__busy        = busy;
  assign wum__mcntl__inst_count  = icnt_q;
  assign wum__mcntl__err_wr      = err_q;

  always_comb begin
    wum__wud__option_type  = '0;
    wum__wud__option_value = '0;
    for (int i = 0; i < OPT_PER_INST; i++) begin
      wum__wud__option_type[i*OPT_TYPE_W +: OPT_TYPE_W] =
        head[HDR_W + i*PAIR_W +: OPT_TYPE_W];
      wum__wud__option_value[i*OPT_VALUE_W +: OPT_VALUE_W] =
        head[HDR_W + i*PAIR_W + OPT_TYPE_W +: OPT_VALUE_W];
    end
  end

endmodule
